// File: rtl/window_stats_pkg.sv
// Shared types, constants and width helpers for the window_stats slice.
package window_stats_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    // Register stages between reading a sample and it reaching the accumulators.
    localparam int PIPE_DEPTH = 2;

    function automatic int idx_w(input int length);
        return $clog2(length);
    endfunction

    // Wide enough for LENGTH squares of a full-scale negative sample.
    function automatic int sum_w(input int wordwidth, input int length);
        return 2 * wordwidth - 1 + idx_w(length);
    endfunction

endpackage

// File: rtl/window_stats_if.sv
// Window in / statistics out bundle between the sample-window shift register
// side (master) and the window_stats analyser (slave).
// Optional WINDOW_STATS_MEAN_EN adds the signed sum and mean result signals.
interface window_stats_if
    import window_stats_pkg::*;
#(
    parameter int LENGTH    = 1024,
    parameter int WORDWIDTH = 8
);
    localparam int IDXW = idx_w(LENGTH);
    localparam int SUMW = sum_w(WORDWIDTH, LENGTH);

    logic                        start;
    logic signed [WORDWIDTH-1:0] dataIn [0:LENGTH-1];
    logic                        freeze;
    logic                        busy;
    logic                        done;
    logic [WORDWIDTH-1:0]        peakAbs;
    logic [IDXW-1:0]             peakIdx;
    logic [SUMW-1:0]             energy;
`ifdef WINDOW_STATS_MEAN_EN
    logic signed [WORDWIDTH+IDXW-1:0] sum;
    logic signed [WORDWIDTH-1:0]      mean;

    modport master (
        output start, dataIn,
        input  freeze, busy, done, peakAbs, peakIdx, energy, sum, mean
    );
    modport slave (
        input  start, dataIn,
        output freeze, busy, done, peakAbs, peakIdx, energy, sum, mean
    );
`else
    modport master (
        output start, dataIn,
        input  freeze, busy, done, peakAbs, peakIdx, energy
    );
    modport slave (
        input  start, dataIn,
        output freeze, busy, done, peakAbs, peakIdx, energy
    );
`endif

endinterface

// File: rtl/window_stats_acc.sv
// Two-stage abs/square/compare/accumulate datapath for window_stats.
// Stage 1 registers |sample| and its index; stage 2 squares, accumulates
// energy and tracks the peak (strict greater-than, so ties keep the lowest
// index). Optional WINDOW_STATS_MEAN_EN adds a signed running sum.
module window_stats_acc
    import window_stats_pkg::*;
#(
    parameter int LENGTH    = 1024,
    parameter int WORDWIDTH = 8,
    localparam int IDXW     = idx_w(LENGTH),
    localparam int SUMW     = sum_w(WORDWIDTH, LENGTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        valid,
    input  logic signed [WORDWIDTH-1:0] sample,
    input  logic [IDXW-1:0]             idx,
    output logic [WORDWIDTH-1:0]        peakAbs,
    output logic [IDXW-1:0]             peakIdx,
`ifdef WINDOW_STATS_MEAN_EN
    output logic signed [WORDWIDTH+IDXW-1:0] sum,
`endif
    output logic [SUMW-1:0]             energy
);

    logic signed [WORDWIDTH:0]  sample_ext;
    logic [WORDWIDTH:0]         abs_ext;
    logic                       s1_valid;
    logic [WORDWIDTH-1:0]       s1_abs;
    logic [IDXW-1:0]            s1_idx;
    logic [2*WORDWIDTH-1:0]     sq;
`ifdef WINDOW_STATS_MEAN_EN
    logic signed [WORDWIDTH-1:0] s1_sample;
`endif

    // Magnitude in one extra bit so the most negative sample maps losslessly.
    always_comb begin
        sample_ext = (WORDWIDTH + 1)'(sample);
        abs_ext    = sample_ext[WORDWIDTH] ? $unsigned(-sample_ext) : $unsigned(sample_ext);
        sq         = (2 * WORDWIDTH)'(s1_abs) * (2 * WORDWIDTH)'(s1_abs);
    end

    // Stage 1: capture magnitude and index of the sample being read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_abs    <= '0;
            s1_idx    <= '0;
`ifdef WINDOW_STATS_MEAN_EN
            s1_sample <= '0;
`endif
        end else if (clear) begin
            s1_valid  <= 1'b0;
            s1_abs    <= '0;
            s1_idx    <= '0;
`ifdef WINDOW_STATS_MEAN_EN
            s1_sample <= '0;
`endif
        end else begin
            s1_valid <= valid;
            if (valid) begin
                s1_abs    <= WORDWIDTH'(abs_ext);
                s1_idx    <= idx;
`ifdef WINDOW_STATS_MEAN_EN
                s1_sample <= sample;
`endif
            end
        end
    end

    // Stage 2: accumulate energy (and sum) and keep the first-seen peak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peakAbs <= '0;
            peakIdx <= '0;
            energy  <= '0;
`ifdef WINDOW_STATS_MEAN_EN
            sum     <= '0;
`endif
        end else if (clear) begin
            peakAbs <= '0;
            peakIdx <= '0;
            energy  <= '0;
`ifdef WINDOW_STATS_MEAN_EN
            sum     <= '0;
`endif
        end else if (s1_valid) begin
            energy <= energy + SUMW'(sq);
            if (s1_abs > peakAbs) begin
                peakAbs <= s1_abs;
                peakIdx <= s1_idx;
            end
`ifdef WINDOW_STATS_MEAN_EN
            sum <= sum + (WORDWIDTH + IDXW)'(s1_sample);
`endif
        end
    end

endmodule

// File: rtl/window_stats.sv
// window_stats: freezes the upstream sample window on start, scans it one
// sample per cycle through window_stats_acc, and publishes peak |sample|,
// its index and the window energy with a one-cycle done pulse.
// Optional WINDOW_STATS_MEAN_EN adds signed sum and mean outputs
// (LENGTH must then be a power of two).
module window_stats
    import window_stats_pkg::*;
#(
    parameter int LENGTH    = 1024,
    parameter int WORDWIDTH = 8,
    localparam int IDXW     = idx_w(LENGTH),
    localparam int SUMW     = sum_w(WORDWIDTH, LENGTH)
) (
    input  logic          clk,
    input  logic          rst,
    window_stats_if.slave bus
);

    if (LENGTH < 2) begin : g_len_min
        $error("window_stats: LENGTH must be at least 2");
    end

`ifdef WINDOW_STATS_MEAN_EN
    if ((LENGTH & (LENGTH - 1)) != 0) begin : g_len_pow2
        $error("window_stats: LENGTH must be a power of two when the mean is enabled");
    end
`endif

    state_t                      state;
    state_t                      next_state;
    logic [IDXW-1:0]             idx;
    logic                        last_idx;
    logic                        drain_last;
    logic                        acc_clear;
    logic                        acc_valid;
    logic                        hold_next;
    logic signed [WORDWIDTH-1:0] sample;

    logic [WORDWIDTH-1:0]        acc_peak;
    logic [IDXW-1:0]             acc_idx;
    logic [SUMW-1:0]             acc_energy;

    logic                        freeze_q;
    logic                        busy_q;
    logic                        done_q;
    logic [WORDWIDTH-1:0]        peak_q;
    logic [IDXW-1:0]             pidx_q;
    logic [SUMW-1:0]             energy_q;
`ifdef WINDOW_STATS_MEAN_EN
    logic signed [WORDWIDTH+IDXW-1:0] acc_sum;
    logic signed [WORDWIDTH+IDXW-1:0] sum_q;
    logic signed [WORDWIDTH-1:0]      mean_q;
`endif

    // The index counter is reused to count pipeline-flush cycles in DRAIN.
    assign last_idx   = (idx == IDXW'(LENGTH - 1));
    assign drain_last = (idx == IDXW'(PIPE_DEPTH - 1));
    assign sample     = bus.dataIn[idx];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath controls.
    always_comb begin
        next_state = state;
        acc_clear  = 1'b0;
        acc_valid  = 1'b0;
        unique case (state)
            IDLE:    if (bus.start) next_state = SETTLE;
            SETTLE: begin
                acc_clear  = 1'b1;
                next_state = SCAN;
            end
            SCAN: begin
                acc_valid = 1'b1;
                if (last_idx) next_state = DRAIN;
            end
            DRAIN:   if (drain_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        hold_next = (next_state == SETTLE) || (next_state == SCAN) || (next_state == DRAIN);
    end

    // Sample index during SCAN, flush counter during DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else begin
            unique case (state)
                SCAN:    idx <= last_idx ? '0 : idx + 1'b1;
                DRAIN:   idx <= idx + 1'b1;
                default: idx <= '0;
            endcase
        end
    end

    window_stats_acc #(
        .LENGTH    (LENGTH),
        .WORDWIDTH (WORDWIDTH)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .valid   (acc_valid),
        .sample  (sample),
        .idx     (idx),
        .peakAbs (acc_peak),
        .peakIdx (acc_idx),
`ifdef WINDOW_STATS_MEAN_EN
        .sum     (acc_sum),
`endif
        .energy  (acc_energy)
    );

    // Registered status flags and result registers, loaded on entry to DONE
    // so the results are already visible in the done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freeze_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            peak_q   <= '0;
            pidx_q   <= '0;
            energy_q <= '0;
`ifdef WINDOW_STATS_MEAN_EN
            sum_q    <= '0;
            mean_q   <= '0;
`endif
        end else begin
            freeze_q <= hold_next;
            busy_q   <= hold_next;
            done_q   <= (next_state == DONE);
            if (next_state == DONE) begin
                peak_q   <= acc_peak;
                pidx_q   <= acc_idx;
                energy_q <= acc_energy;
`ifdef WINDOW_STATS_MEAN_EN
                sum_q    <= acc_sum;
                mean_q   <= WORDWIDTH'(acc_sum >>> IDXW);
`endif
            end
        end
    end

    assign bus.freeze  = freeze_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.peakAbs = peak_q;
    assign bus.peakIdx = pidx_q;
    assign bus.energy  = energy_q;
`ifdef WINDOW_STATS_MEAN_EN
    assign bus.sum     = sum_q;
    assign bus.mean    = mean_q;
`endif

endmodule

// File: tb/tb_window_stats.sv
// Self-checking bench for window_stats (LENGTH=8, WORDWIDTH=8) against a
// behavioural model of the window statistics. Build with
// WINDOW_STATS_MEAN_EN defined to also cover sum and mean.
module tb_window_stats;

    localparam int LENGTH    = 8;
    localparam int WORDWIDTH = 8;
    localparam int LAT       = LENGTH + 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    window_stats_if #(.LENGTH(LENGTH), .WORDWIDTH(WORDWIDTH)) bus ();

    window_stats #(.LENGTH(LENGTH), .WORDWIDTH(WORDWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int win [LENGTH];
    int exp_peak, exp_idx, exp_energy, exp_sum, exp_mean;
    int held_peak = 0, held_idx = 0, held_energy = 0, held_sum = 0, held_mean = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < LENGTH; i++) bus.dataIn[i] = WORDWIDTH'(win[i]);
    endtask

    // Reference: plain arithmetic over the window contents.
    task automatic model();
        exp_peak = 0; exp_idx = 0; exp_energy = 0; exp_sum = 0;
        for (int i = 0; i < LENGTH; i++) begin
            int m;
            m = (win[i] < 0) ? -win[i] : win[i];
            if (m > exp_peak) begin
                exp_peak = m;
                exp_idx  = i;
            end
            exp_energy += win[i] * win[i];
            exp_sum    += win[i];
        end
        exp_mean = (exp_sum >= 0) ? exp_sum / LENGTH : -((-exp_sum + LENGTH - 1) / LENGTH);
    endtask

    task automatic chk_results(input string tag, input int p, input int ix, input int e, input int s, input int mn);
        chk({tag, ".peakAbs"}, bus.peakAbs, p);
        chk({tag, ".peakIdx"}, bus.peakIdx, ix);
        chk({tag, ".energy"},  bus.energy,  e);
`ifdef WINDOW_STATS_MEAN_EN
        chk({tag, ".sum"},  bus.sum,  s);
        chk({tag, ".mean"}, bus.mean, mn);
`else
        if (s != mn) begin end
`endif
    endtask

    // Start a scan of the current window and check every cycle up to and
    // just past done; optionally pulse start mid-scan or in the done cycle.
    task automatic run(input string tag, input bit mid_start, input bit done_start);
        model();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            bit in_flight;
            in_flight = (k <= LAT - 1);
            chk({tag, ".freeze"}, bus.freeze, in_flight);
            chk({tag, ".busy"},   bus.busy,   in_flight);
            chk({tag, ".done"},   bus.done,   k == LAT);
            if (k < LAT) begin
                chk_results({tag, ".hold"}, held_peak, held_idx, held_energy, held_sum, held_mean);
            end else begin
                chk_results(tag, exp_peak, exp_idx, exp_energy, exp_sum, exp_mean);
            end
            if (k == LAT) begin
                held_peak = exp_peak; held_idx = exp_idx; held_energy = exp_energy;
                held_sum = exp_sum; held_mean = exp_mean;
            end
            bus.start = (mid_start && k == 4) || (done_start && k == LAT);
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < LENGTH; i++) win[i] = i + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held low with random window contents and start pulses.
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < LENGTH; i++) win[i] = int'($urandom_range(0, 255)) - 128;
        apply();
        for (int c = 0; c < 5; c++) begin
            bus.start = 1'($urandom_range(0, 1));
            tick();
            chk("rst.freeze", bus.freeze, 0);
            chk("rst.busy",   bus.busy,   0);
            chk("rst.done",   bus.done,   0);
            chk_results("rst", 0, 0, 0, 0, 0);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle.freeze", bus.freeze, 0);
            chk("idle.done",   bus.done,   0);
            chk_results("idle", 0, 0, 0, 0, 0);
        end

        // Single full-scale negative sample.
        for (int i = 0; i < LENGTH; i++) win[i] = 0;
        win[5] = -128;
        apply();
        run("extreme", 1'b0, 1'b0);
        chk("extreme.model_peak", exp_peak, 128);
        chk("extreme.model_energy", exp_energy, 16384);

        // Equal magnitudes: lowest index wins.
        for (int i = 0; i < LENGTH; i++) win[i] = 0;
        win[2] = 50;
        win[6] = -50;
        apply();
        run("tie", 1'b0, 1'b1);

        // Ramp with a start pulse mid-scan that must be ignored.
        set_ramp();
        apply();
        run("ramp", 1'b1, 1'b0);
        chk("ramp.model_energy", exp_energy, 204);

        // Abort during SCAN at index 4.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        chk("abort.pre_freeze", bus.freeze, 1);
        rst = 1'b0;
        #1;
        chk("abort.freeze", bus.freeze, 0);
        chk("abort.busy",   bus.busy,   0);
        chk("abort.done",   bus.done,   0);
        chk_results("abort", 0, 0, 0, 0, 0);
        held_peak = 0; held_idx = 0; held_energy = 0; held_sum = 0; held_mean = 0;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            chk("abort.no_done", bus.done, 0);
            chk("abort.idle_freeze", bus.freeze, 0);
        end
        run("restart", 1'b0, 1'b0);

`ifdef WINDOW_STATS_MEAN_EN
        for (int i = 0; i < LENGTH; i++) win[i] = -3;
        apply();
        run("neg3", 1'b0, 1'b0);
        for (int i = 0; i < LENGTH; i++) win[i] = (i % 2 == 0) ? 1 : -2;
        apply();
        run("alt", 1'b0, 1'b0);
`endif

        // Random windows, with full-scale values injected at times.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < LENGTH; i++) begin
                case ($urandom_range(0, 7))
                    0:       win[i] = -128;
                    1:       win[i] = 127;
                    default: win[i] = int'($urandom_range(0, 255)) - 128;
                endcase
            end
            apply();
            run($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_stats.md
Name: window_stats

Overview:
- Downstream consumer of the sample-window shift register.
- On a start pulse, freezes the window by driving the shift register's enable gate low, then scans it sequentially one sample per cycle.
- Produces peak absolute value, the index of that peak, and window energy (sum of squares).
- Results feed the DEMO display/control logic; the scan costs one multiplier instead of LENGTH.

Parameters:
- LENGTH, 1024, window depth in samples; must match the upstream shift register; at least 2.
- WORDWIDTH, 8, bits per signed sample.
- Derived, not overridable: IDXW = $clog2(LENGTH); SUMW = 2*WORDWIDTH - 1 + IDXW.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to analyse the current window.
- dataIn  in  signed [WORDWIDTH-1:0] x [0:LENGTH-1]  window contents from the shift register.
- freeze  out  1  high while the window must not shift; upstream enable = sampleValid & ~freeze.
- busy  out  1  high from the cycle after start is accepted through the cycle before done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- peakAbs  out  [WORDWIDTH-1:0]  unsigned max |sample|; -2^(W-1) maps to 2^(W-1).
- peakIdx  out  [IDXW-1:0]  index of peakAbs.
- energy  out  [SUMW-1:0]  unsigned sum of squares; cannot overflow.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; freeze, busy, done = 0; peakAbs, peakIdx, energy = 0; internal index and accumulators = 0.
- FSM states: IDLE, SETTLE, SCAN, DRAIN, DONE.
- IDLE: start=1 -> SETTLE. All outputs are registered.
- SETTLE (1 cycle): freeze=1. Absorbs the final upstream shift that may land on the edge at which freeze rises. Clears the accumulators, sets idx=0 -> SCAN.
- SCAN (LENGTH cycles): reads dataIn[idx] into a 2-stage pipeline. Stage 1 registers the sample and its |sample|. Stage 2 squares, accumulates energy, and compares the magnitude.
  - Peak update only on strict greater-than, so ties keep the lowest index.
  - idx == LENGTH-1 -> DRAIN.
- DRAIN (2 cycles): flushes the pipeline -> DONE.
- DONE (1 cycle): done=1, freeze=0, busy=0. Copies the results to the output registers -> IDLE.
- Outputs hold their values until the next DONE; they do not change during a scan.
- Latency: start sampled at edge t gives done high in cycle t+LENGTH+4. freeze is high for cycles t+1 .. t+LENGTH+3.
- start while not in IDLE is ignored (no queueing). start in the DONE cycle is also ignored.
- rst mid-scan aborts immediately: freeze drops, partial results are discarded, outputs are zeroed.
- Arithmetic:
  - abs is computed in WORDWIDTH+1 bits, then truncated to WORDWIDTH unsigned (lossless).
  - Square is 2*WORDWIDTH bits unsigned.
  - Accumulator is SUMW bits with no saturation needed.

Optional Feature:
- Macro: WINDOW_STATS_MEAN_EN.
- Defined:
  - Adds output sum (signed [WORDWIDTH+IDXW-1:0], signed sum of samples) and output mean (signed [WORDWIDTH-1:0] = sum >>> IDXW, arithmetic shift, rounds toward -inf).
  - Both are updated in the DONE cycle and reset to 0.
  - LENGTH must be a power of two; enforce with an elaboration-time check.
- Undefined: no sum or mean ports or logic; behaviour otherwise identical.

Decomposition:
- Package window_stats_pkg holds:
  - state_t enum (IDLE, SETTLE, SCAN, DRAIN, DONE).
  - Width helper functions idx_w(LENGTH) and sum_w(WORDWIDTH, LENGTH).
  - Constant PIPE_DEPTH = 2.
- Sub-module window_stats_acc: the 2-stage abs/square/compare/accumulate datapath.
  - Inputs: sample, idx, valid, clear.
  - Outputs: running peakAbs, peakIdx, energy (and sum under the macro).
  - The top level keeps the FSM, index counter, and output registers.

Test Plan (LENGTH=8, WORDWIDTH=8):
- Reset: hold rst=0 with random dataIn and start pulses -> freeze, busy, done, peakAbs, peakIdx, energy all 0; after release with no start, outputs stay 0.
- Single extreme: dataIn all 0 except [5]=-128, start at edge t -> done exactly at cycle t+12, peakAbs=128, peakIdx=5, energy=16384; freeze high cycles t+1..t+11 only.
- Tie: [2]=50, [6]=-50, rest 0 -> peakAbs=50, peakIdx=2, energy=5000.
- Ramp: dataIn[i]=i+1 -> peakAbs=8, peakIdx=7, energy=204. A second start pulsed mid-scan is ignored (exactly one done).
- Abort: rst=0 at SCAN idx 4 -> freeze falls asynchronously, outputs 0, no done. Restart on the ramp yields 8 / 7 / 204.
- WINDOW_STATS_MEAN_EN: all samples -3 -> sum=-24, mean=-3; samples alternating 1,-2 -> sum=-4, mean=-1.
